// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: shared states, opcodes, funct codes and ALU encodings (JUMP state only with MIPS_JUMP_EN)
package multicycle_controller_pkg;
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEX   = 4'd9,
`ifdef MIPS_JUMP_EN
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
`else
        ADDIWB   = 4'd10
`endif
    } mc_state_t;

    typedef enum logic [1:0] {AOP_ADD, AOP_SUB, AOP_FUNCT} alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: shared memory port request/ready handshake
interface multicycle_controller_if;
    logic mem_req;
    logic mem_rdy;
    logic iord;
    logic memwrite;
    modport master (output mem_req, iord, memwrite, input mem_rdy);
    modport slave  (input mem_req, iord, memwrite, output mem_rdy);
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// multicycle_controller_alu_decoder: maps ALU op class and funct field to ALU control
module multicycle_controller_alu_decoder
    import multicycle_controller_pkg::*;
#(
    parameter int FUNCT_WIDTH = 6
) (
    input  alu_op_t                alu_op,
    input  logic [FUNCT_WIDTH-1:0] Funct,
    output logic [2:0]             alu_control
);
    // unknown funct codes fall back to add
    assign alu_control = alu_op == AOP_ADD ? ALU_ADD :
                         alu_op == AOP_SUB ? ALU_SUB :
                         Funct == FN_SUB   ? ALU_SUB :
                         Funct == FN_AND   ? ALU_AND :
                         Funct == FN_OR    ? ALU_OR  :
                         Funct == FN_SLT   ? ALU_SLT : ALU_ADD;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore sequencing FSM for the shared-memory multicycle MIPS datapath (MIPS_JUMP_EN adds j)
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int OP_WIDTH    = 6,
    parameter int FUNCT_WIDTH = 6
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [OP_WIDTH-1:0]    OP,
    input  logic [FUNCT_WIDTH-1:0] Funct,
    input  logic                   zero,
    multicycle_controller_if.master mem,
    output logic                   irwrite,
    output logic                   regdst,
    output logic                   mem2reg,
    output logic                   regwrite,
    output logic                   alu_srca,
    output logic [1:0]             alu_srcb,
    output logic [1:0]             pc_src,
    output logic [2:0]             alu_control,
    output logic                   pc_en,
    output logic [3:0]             state_o
);
    mc_state_t state, next;
    alu_op_t   alu_op;
    logic      pc_write, branch;

    // state register, reset lands in FETCH immediately
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= FETCH;
        else        state <= next;
    end

    // next state and Moore outputs; only memory-handshake enables look at mem_rdy
    always_comb begin
        next         = state;
        mem.mem_req  = 1'b0;
        mem.iord     = 1'b0;
        mem.memwrite = 1'b0;
        irwrite      = 1'b0;
        regdst       = 1'b0;
        mem2reg      = 1'b0;
        regwrite     = 1'b0;
        alu_srca     = 1'b0;
        alu_srcb     = 2'b00;
        pc_src       = 2'b00;
        alu_op       = AOP_ADD;
        pc_write     = 1'b0;
        branch       = 1'b0;
        case (state)
            FETCH: begin
                mem.mem_req = 1'b1;
                alu_srcb    = 2'b01;
                irwrite     = mem.mem_rdy;
                pc_write    = mem.mem_rdy;
                next        = mem.mem_rdy ? DECODE : FETCH;
            end
            DECODE: begin
                alu_srcb = 2'b11;
                case (OP)
                    OP_LW, OP_SW: next = MEMADR;
                    OP_RTYPE:     next = EXECUTE;
                    OP_BEQ:       next = BRANCH;
                    OP_ADDI:      next = ADDIEX;
`ifdef MIPS_JUMP_EN
                    OP_J:         next = JUMP;
`endif
                    default:      next = FETCH;
                endcase
            end
            MEMADR: begin
                alu_srca = 1'b1;
                alu_srcb = 2'b10;
                next     = OP == OP_SW ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem.mem_req = 1'b1;
                mem.iord    = 1'b1;
                next        = mem.mem_rdy ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                mem2reg  = 1'b1;
                regwrite = 1'b1;
                next     = FETCH;
            end
            MEMWRITE: begin
                mem.mem_req  = 1'b1;
                mem.iord     = 1'b1;
                mem.memwrite = mem.mem_rdy;
                next         = mem.mem_rdy ? FETCH : MEMWRITE;
            end
            EXECUTE: begin
                alu_srca = 1'b1;
                alu_op   = AOP_FUNCT;
                next     = ALUWB;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                next     = FETCH;
            end
            BRANCH: begin
                alu_srca = 1'b1;
                alu_op   = AOP_SUB;
                pc_src   = 2'b01;
                branch   = 1'b1;
                next     = FETCH;
            end
            ADDIEX: begin
                alu_srca = 1'b1;
                alu_srcb = 2'b10;
                next     = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
                next     = FETCH;
            end
`ifdef MIPS_JUMP_EN
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                next     = FETCH;
            end
`endif
            default: next = FETCH;
        endcase
    end

    assign pc_en   = pc_write | (branch & zero);
    assign state_o = state;

    multicycle_controller_alu_decoder #(.FUNCT_WIDTH(FUNCT_WIDTH)) alu_decoder (
        .alu_op      (alu_op),
        .Funct       (Funct),
        .alu_control (alu_control)
    );
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table-driven instruction traces plus hand-written wait/reset sequences
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    typedef struct packed {
        logic [5:0]      op;
        logic [5:0]      fn;
        logic            z;
        logic [2:0]      n;
        logic [4:0][3:0] seq;
        logic [4:0]      rw;
        logic [4:0]      mw;
        logic [4:0]      pe;
        logic            m2r;
        logic            rdst;
        logic [2:0]      alu2;
        logic [1:0]      pcs2;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [5:0] OP;
    logic [5:0] Funct;
    logic       zero;
    logic       irwrite, regdst, mem2reg, regwrite, alu_srca, pc_en;
    logic [1:0] alu_srcb, pc_src;
    logic [2:0] alu_control;
    logic [3:0] state_o;
    int         checks = 0;
    int         errors = 0;
    vec_t       vq[$];

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .OP          (OP),
        .Funct       (Funct),
        .zero        (zero),
        .mem         (bus),
        .irwrite     (irwrite),
        .regdst      (regdst),
        .mem2reg     (mem2reg),
        .regwrite    (regwrite),
        .alu_srca    (alu_srca),
        .alu_srcb    (alu_srcb),
        .pc_src      (pc_src),
        .alu_control (alu_control),
        .pc_en       (pc_en),
        .state_o     (state_o)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic [2:0] n,
                                input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                                input logic [3:0] s3, input logic [3:0] s4,
                                input logic [4:0] rw, input logic [4:0] mw, input logic [4:0] pe,
                                input logic m2r, input logic rdst, input logic [2:0] alu2, input logic [1:0] pcs2);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.n = n;
        v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2; v.seq[3] = s3; v.seq[4] = s4;
        v.rw = rw; v.mw = mw; v.pe = pe; v.m2r = m2r; v.rdst = rdst; v.alu2 = alu2; v.pcs2 = pcs2;
        return v;
    endfunction

    initial begin
        int cyc;
        vq.push_back(mk(6'b100011, 6'b000000, 1'b0, 3'd5, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, 5'b10000, 5'b00000, 5'b00001, 1'b1, 1'b0, 3'b010, 2'b00));
        vq.push_back(mk(6'b101011, 6'b000000, 1'b0, 3'd4, FETCH, DECODE, MEMADR, MEMWRITE, FETCH, 5'b00000, 5'b01000, 5'b00001, 1'b0, 1'b0, 3'b010, 2'b00));
        vq.push_back(mk(6'b000000, 6'b100000, 1'b0, 3'd4, FETCH, DECODE, EXECUTE, ALUWB, FETCH, 5'b01000, 5'b00000, 5'b00001, 1'b0, 1'b1, 3'b010, 2'b00));
        vq.push_back(mk(6'b000000, 6'b100010, 1'b0, 3'd4, FETCH, DECODE, EXECUTE, ALUWB, FETCH, 5'b01000, 5'b00000, 5'b00001, 1'b0, 1'b1, 3'b110, 2'b00));
        vq.push_back(mk(6'b000000, 6'b100100, 1'b0, 3'd4, FETCH, DECODE, EXECUTE, ALUWB, FETCH, 5'b01000, 5'b00000, 5'b00001, 1'b0, 1'b1, 3'b000, 2'b00));
        vq.push_back(mk(6'b000000, 6'b100101, 1'b0, 3'd4, FETCH, DECODE, EXECUTE, ALUWB, FETCH, 5'b01000, 5'b00000, 5'b00001, 1'b0, 1'b1, 3'b001, 2'b00));
        vq.push_back(mk(6'b000000, 6'b101010, 1'b0, 3'd4, FETCH, DECODE, EXECUTE, ALUWB, FETCH, 5'b01000, 5'b00000, 5'b00001, 1'b0, 1'b1, 3'b111, 2'b00));
        vq.push_back(mk(6'b000000, 6'b111111, 1'b0, 3'd4, FETCH, DECODE, EXECUTE, ALUWB, FETCH, 5'b01000, 5'b00000, 5'b00001, 1'b0, 1'b1, 3'b010, 2'b00));
        vq.push_back(mk(6'b000100, 6'b000000, 1'b1, 3'd3, FETCH, DECODE, BRANCH, FETCH, FETCH, 5'b00000, 5'b00000, 5'b00101, 1'b0, 1'b0, 3'b110, 2'b01));
        vq.push_back(mk(6'b000100, 6'b000000, 1'b0, 3'd3, FETCH, DECODE, BRANCH, FETCH, FETCH, 5'b00000, 5'b00000, 5'b00001, 1'b0, 1'b0, 3'b110, 2'b01));
        vq.push_back(mk(6'b001000, 6'b000000, 1'b0, 3'd4, FETCH, DECODE, ADDIEX, ADDIWB, FETCH, 5'b01000, 5'b00000, 5'b00001, 1'b0, 1'b0, 3'b010, 2'b00));
`ifdef MIPS_JUMP_EN
        vq.push_back(mk(6'b000010, 6'b000000, 1'b0, 3'd3, FETCH, DECODE, JUMP, FETCH, FETCH, 5'b00000, 5'b00000, 5'b00101, 1'b0, 1'b0, 3'b010, 2'b10));
`else
        vq.push_back(mk(6'b000010, 6'b000000, 1'b0, 3'd2, FETCH, DECODE, FETCH, FETCH, FETCH, 5'b00000, 5'b00000, 5'b00001, 1'b0, 1'b0, 3'b010, 2'b00));
`endif
        vq.push_back(mk(6'b111111, 6'b000000, 1'b0, 3'd2, FETCH, DECODE, FETCH, FETCH, FETCH, 5'b00000, 5'b00000, 5'b00001, 1'b0, 1'b0, 3'b010, 2'b00));

        RST_N = 1'b0; OP = 6'b0; Funct = 6'b0; zero = 1'b0; bus.mem_rdy = 1'b0;
        step();
        chk("rst state", 32'(state_o), 32'(FETCH));
        chk("rst mem_req", 32'(bus.mem_req), 32'd1);
        chk("rst alu_srcb", 32'(alu_srcb), 32'd1);
        chk("rst alu_control", 32'(alu_control), 32'd2);
        chk("rst zeros", {25'd0, bus.memwrite, regwrite, regdst, mem2reg, bus.iord, alu_srca, |pc_src}, 32'd0);
        chk("rst irwrite rdy0", 32'(irwrite), 32'd0);
        chk("rst pc_en rdy0", 32'(pc_en), 32'd0);
        bus.mem_rdy = 1'b1;
        #1;
        chk("rst irwrite rdy1", 32'(irwrite), 32'd1);
        chk("rst pc_en rdy1", 32'(pc_en), 32'd1);
        step();
        chk("rst held", 32'(state_o), 32'(FETCH));
        RST_N = 1'b1;

        foreach (vq[i]) begin
            OP = vq[i].op; Funct = vq[i].fn; zero = vq[i].z;
            for (int c = 0; c < 32'(vq[i].n); c++) begin
                #1;
                chk($sformatf("v%0d c%0d state", i, c), 32'(state_o), 32'(vq[i].seq[c]));
                chk($sformatf("v%0d c%0d regwrite", i, c), 32'(regwrite), 32'(vq[i].rw[c]));
                chk($sformatf("v%0d c%0d memwrite", i, c), 32'(bus.memwrite), 32'(vq[i].mw[c]));
                chk($sformatf("v%0d c%0d pc_en", i, c), 32'(pc_en), 32'(vq[i].pe[c]));
                if (c == 2) begin
                    chk($sformatf("v%0d alu_control", i), 32'(alu_control), 32'(vq[i].alu2));
                    chk($sformatf("v%0d pc_src", i), 32'(pc_src), 32'(vq[i].pcs2));
                end
                if (vq[i].rw[c]) begin
                    chk($sformatf("v%0d mem2reg", i), 32'(mem2reg), 32'(vq[i].m2r));
                    chk($sformatf("v%0d regdst", i), 32'(regdst), 32'(vq[i].rdst));
                end
                @(negedge CLK);
            end
            #1;
            chk($sformatf("v%0d end state", i), 32'(state_o), 32'(FETCH));
        end

        OP = OP_ADDI; bus.mem_rdy = 1'b0;
        #1;
        chk("fw c0 state", 32'(state_o), 32'(FETCH));
        chk("fw c0 irwrite", 32'(irwrite), 32'd0);
        step();
        chk("fw c1 state", 32'(state_o), 32'(FETCH));
        chk("fw c1 mem_req", 32'(bus.mem_req), 32'd1);
        chk("fw c1 alu_srcb", 32'(alu_srcb), 32'd1);
        bus.mem_rdy = 1'b1;
        #1;
        chk("fw c2 irwrite", 32'(irwrite), 32'd1);
        step();
        chk("fw decode", 32'(state_o), 32'(DECODE));
        step();
        chk("fw addiex", 32'(state_o), 32'(ADDIEX));
        step();
        chk("fw addiwb", 32'(state_o), 32'(ADDIWB));
        step();
        chk("fw end", 32'(state_o), 32'(FETCH));

        OP = OP_SW; cyc = 0;
        chk("sw c0 state", 32'(state_o), 32'(FETCH));
        step(); cyc++;
        step(); cyc++;
        chk("sw c2 state", 32'(state_o), 32'(MEMADR));
        step(); cyc++;
        bus.mem_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("sw wait%0d state", k), 32'(state_o), 32'(MEMWRITE));
            chk($sformatf("sw wait%0d memwrite", k), 32'(bus.memwrite), 32'd0);
            chk($sformatf("sw wait%0d mem_req", k), 32'(bus.mem_req), 32'd1);
            chk($sformatf("sw wait%0d iord", k), 32'(bus.iord), 32'd1);
            step(); cyc++;
        end
        bus.mem_rdy = 1'b1;
        #1;
        chk("sw done memwrite", 32'(bus.memwrite), 32'd1);
        step(); cyc++;
        chk("sw end state", 32'(state_o), 32'(FETCH));
        chk("sw cycles", 32'(cyc), 32'd7);

        OP = OP_LW;
        step();
        chk("lr decode", 32'(state_o), 32'(DECODE));
        bus.mem_rdy = 1'b0;
        step();
        chk("lr memadr ignores rdy", 32'(state_o), 32'(MEMADR));
        step();
        chk("lr memread", 32'(state_o), 32'(MEMREAD));
        step();
        chk("lr memread hold", 32'(state_o), 32'(MEMREAD));
        chk("lr memread iord", 32'(bus.iord), 32'd1);
        RST_N = 1'b0;
        #1;
        chk("lr reset state", 32'(state_o), 32'(FETCH));
        chk("lr reset regwrite", 32'(regwrite), 32'd0);
        chk("lr reset memwrite", 32'(bus.memwrite), 32'd0);
        step();
        RST_N = 1'b1; bus.mem_rdy = 1'b1;
        #1;
        chk("lr restart", 32'(state_o), 32'(FETCH));
        step();
        chk("lr restart decode", 32'(state_o), 32'(DECODE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
